// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared defaults and helpers for the sprite ROM arbiter
package sprite_pkg;

    localparam int NUM_REQ     = 4;
    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 16;
    localparam int IDX_W       = $clog2(NUM_REQ);
    localparam int ROM_LATENCY = 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick2.sv
// rtl/sprite_rom_arbiter_rr_pick2.sv - combinational two-grant round-robin picker
module rr_pick2
    import sprite_pkg::*;
#(
    parameter int N  = NUM_REQ,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  req_valid,
    input  logic [IW-1:0] ptr,
    output logic          grant_a_valid,
    output logic [IW-1:0] grant_a_idx,
    output logic          grant_b_valid,
    output logic [IW-1:0] grant_b_idx,
    output logic [IW-1:0] next_ptr
);

    always_comb begin
        int j;
        logic [IW-1:0] j_idx;
        grant_a_valid = 1'b0;
        grant_a_idx   = '0;
        grant_b_valid = 1'b0;
        grant_b_idx   = '0;
        next_ptr      = ptr;
        j             = 0;
        j_idx         = '0;
        // Scan from ptr upward with wrap; first hit goes to A, second to B.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            j_idx = IW'(j);
            if (req_valid[j_idx]) begin
                if (!grant_a_valid) begin
                    grant_a_valid = 1'b1;
                    grant_a_idx   = j_idx;
                end else if (!grant_b_valid) begin
                    grant_b_valid = 1'b1;
                    grant_b_idx   = j_idx;
                end
            end
        end
        if (grant_b_valid) begin
            next_ptr = IW'(wrap_inc(int'(grant_b_idx), N));
        end else if (grant_a_valid) begin
            next_ptr = IW'(wrap_inc(int'(grant_a_idx), N));
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares the two sprite ROM read ports among NUM_REQ requesters
module sprite_rom_arbiter #(
    parameter int NUM_REQ    = sprite_pkg::NUM_REQ,
    parameter int DATA_WIDTH = sprite_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sprite_pkg::ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
    output logic [ADDR_WIDTH-1:0]            rom_addr_a,
    output logic [ADDR_WIDTH-1:0]            rom_addr_b,
    input  logic [DATA_WIDTH-1:0]            rom_q_a,
    input  logic [DATA_WIDTH-1:0]            rom_q_b
);
    import sprite_pkg::*;

    localparam int IW = $clog2(NUM_REQ);

    logic                         ga_v, gb_v;
    logic [IW-1:0]                ga_i, gb_i;
    logic [IW-1:0]                ptr, ptr_nxt;
    logic [NUM_REQ-1:0]           grant_vec;
    logic [ADDR_WIDTH-1:0]        addr_a, addr_b;

    logic                         s1_va, s1_vb, s2_va, s2_vb;
    logic [IW-1:0]                s1_ta, s1_tb, s2_ta, s2_tb;
    logic [NUM_REQ-1:0]           rsp_dec;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_mux, rsp_hold;

    rr_pick2 #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_valid     (req_valid),
        .ptr           (ptr),
        .grant_a_valid (ga_v),
        .grant_a_idx   (ga_i),
        .grant_b_valid (gb_v),
        .grant_b_idx   (gb_i),
        .next_ptr      (ptr_nxt)
    );

    always_comb begin
        grant_vec = '0;
        if (ga_v) begin
            grant_vec[ga_i] = 1'b1;
        end
        if (gb_v) begin
            grant_vec[gb_i] = 1'b1;
        end
    end

    assign req_ready = reset ? '0 : grant_vec;
    assign addr_a    = req_addr[ga_i*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_b    = req_addr[gb_i*ADDR_WIDTH +: ADDR_WIDTH];

    // S1 launches the ROM address; S2 tracks the tag while the ROM read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            s1_va      <= 1'b0;
            s1_vb      <= 1'b0;
            s1_ta      <= '0;
            s1_tb      <= '0;
            s2_va      <= 1'b0;
            s2_vb      <= 1'b0;
            s2_ta      <= '0;
            s2_tb      <= '0;
            rom_addr_a <= '0;
            rom_addr_b <= '0;
            rsp_hold   <= '0;
        end else begin
            ptr   <= ptr_nxt;
            s1_va <= ga_v;
            s1_vb <= gb_v;
            s1_ta <= ga_i;
            s1_tb <= gb_i;
            if (ga_v) begin
                rom_addr_a <= addr_a;
            end
            if (gb_v) begin
                rom_addr_b <= addr_b;
            end
            s2_va    <= s1_va;
            s2_vb    <= s1_vb;
            s2_ta    <= s1_ta;
            s2_tb    <= s1_tb;
            rsp_hold <= rsp_mux;
        end
    end

    // ROM q arrives the cycle S2 is valid, so the demux is combinational off
    // registered tags; idle slots replay their last word.
    always_comb begin
        rsp_dec = '0;
        rsp_mux = rsp_hold;
        if (s2_va) begin
            rsp_dec[s2_ta] = 1'b1;
        end
        if (s2_vb) begin
            rsp_dec[s2_tb] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s2_va && s2_ta == IW'(i)) begin
                rsp_mux[i*DATA_WIDTH +: DATA_WIDTH] = rom_q_a;
            end else if (s2_vb && s2_tb == IW'(i)) begin
                rsp_mux[i*DATA_WIDTH +: DATA_WIDTH] = rom_q_b;
            end
        end
    end

    assign rsp_valid = reset ? '0 : rsp_dec;
    assign rsp_data  = reset ? '0 : rsp_mux;

endmodule
